// File: rtl/raster_scan_pkg.sv
// Shared types and constants for the raster scan controller.
//   state_e    : controller states IDLE / SCAN / DRAIN
//   KERNEL_C   : Sobel window edge length (3), also the minimum legal frame size
//   LB_LINES_C : number of rotating line buffers
//   POS_W_C    : width of the coordinates carried in win_pos_t
//   win_pos_t  : window centre position {col,row}
package raster_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_e;

  localparam int KERNEL_C   = 3;
  localparam int LB_LINES_C = 3;
  localparam int POS_W_C    = 12;

  typedef struct packed {
    logic [POS_W_C-1:0] col;
    logic [POS_W_C-1:0] row;
  } win_pos_t;

endpackage

// File: rtl/raster_scan_ctrl_counter.sv
// General-purpose up counter used for the column and row positions.
// Non-saturating: it simply rolls over at 2**WIDTH.
//   clk   : clock
//   rst   : synchronous active-high reset, count -> 0
//   clr   : synchronous clear, count -> 0 (takes priority over en)
//   en    : count enable
//   wrap  : when enabled, reload to 0 instead of incrementing
//   count : current value
module raster_scan_ctrl_counter #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             wrap,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/raster_scan_ctrl.sv
// Raster scan controller: turns a pixel stream into 3x3 Sobel window positions.
// Tracks column/row, drives the line-buffer write strobe/address/line select and
// presents each window centre through a single-entry output register.
//
// Optional feature macro: RASTER_SCAN_BORDER_EN
//   undefined : interior windows only, (cols-2)*(rows-2) per frame
//   defined   : one window per pixel plus border_o; DRAIN flushes the last row
//
// Ports
//   clk_i, rst_i           : clock, synchronous active-high reset
//   start_i, cols_i, rows_i: frame start request and frame size (IDLE only)
//   valid_i / ready_o      : upstream pixel handshake
//   win_valid_o/win_ready_i: window handshake toward the kernel
//   win_col_o, win_row_o   : window centre position
//   border_o               : centre on a frame edge (RASTER_SCAN_BORDER_EN only)
//   lb_wr_en_o, lb_addr_o  : line-buffer write strobe and address (current column)
//   lb_sel_o               : line buffer being written, rotates 0,1,2
//   busy_o, done_o, err_o  : status; done_o pulses on the last window handshake,
//                            err_o is sticky until the next legal start
module raster_scan_ctrl
  import raster_scan_pkg::*;
#(
  parameter int WIDTH_P    = 12,
  parameter int MAX_COLS_P = 640,
  parameter int MAX_ROWS_P = 480
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH_P-1:0] cols_i,
  input  logic [WIDTH_P-1:0] rows_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               win_valid_o,
  input  logic               win_ready_i,
  output logic [WIDTH_P-1:0] win_col_o,
  output logic [WIDTH_P-1:0] win_row_o,
  output logic               lb_wr_en_o,
  output logic [WIDTH_P-1:0] lb_addr_o,
  output logic [1:0]         lb_sel_o,
  output logic               busy_o,
  output logic               done_o,
`ifdef RASTER_SCAN_BORDER_EN
  output logic               border_o,
`endif
  output logic               err_o
);

  localparam logic [WIDTH_P-1:0] MIN_SIZE_C = WIDTH_P'(KERNEL_C);
  localparam logic [WIDTH_P-1:0] MAX_COLS_C = WIDTH_P'(MAX_COLS_P);
  localparam logic [WIDTH_P-1:0] MAX_ROWS_C = WIDTH_P'(MAX_ROWS_P);
  localparam logic [WIDTH_P-1:0] ONE_C      = WIDTH_P'(1);
  localparam logic [WIDTH_P-1:0] TWO_C      = WIDTH_P'(2);

  state_e             state;
  logic [WIDTH_P-1:0] cols_q;
  logic [WIDTH_P-1:0] rows_q;
  logic [WIDTH_P-1:0] col;
  logic [WIDTH_P-1:0] row;
  logic [1:0]         lb_sel_q;
  logic               err_q;
  logic               win_valid_q;
  win_pos_t           win_q;
  win_pos_t           win_next;

  logic size_ok;
  logic start_ok;
  logic accept;
  logic slot_free;
  logic last_col;
  logic last_row;
  logic fire;
  logic drain_load;
  logic done;

`ifdef RASTER_SCAN_BORDER_EN
  logic border_q;
  logic border_next;
  logic drain_pend;
`endif

  assign size_ok  = (cols_i >= MIN_SIZE_C) && (cols_i <= MAX_COLS_C) &&
                    (rows_i >= MIN_SIZE_C) && (rows_i <= MAX_ROWS_C);
  assign start_ok = (state == IDLE) && start_i && size_ok;

  // The output register can take a new window when empty or being emptied this cycle,
  // which keeps one pixel per cycle flowing under continuous win_ready_i.
  assign slot_free = ~win_valid_q | win_ready_i;
  assign ready_o   = (state == SCAN) & slot_free;
  assign accept    = valid_i & ready_o;
  assign last_col  = (col == cols_q - ONE_C);
  assign last_row  = (row == rows_q - ONE_C);

`ifdef RASTER_SCAN_BORDER_EN
  assign done = (state == DRAIN) & win_valid_q & win_ready_i & ~drain_pend;
`else
  assign done = (state == DRAIN) & win_valid_q & win_ready_i;
`endif

  // Window generation. Interior mode centres the window one pixel up-left of the
  // accepted pixel. Border mode centres it one line above the accepted pixel, so the
  // last frame line has no later pixel to trigger it and is replayed from DRAIN.
  always_comb begin
    fire       = 1'b0;
    drain_load = 1'b0;
    win_next   = '0;
`ifdef RASTER_SCAN_BORDER_EN
    border_next = 1'b0;
    drain_load  = (state == DRAIN) & drain_pend & slot_free;
    if (accept && (row >= ONE_C)) begin
      fire         = 1'b1;
      win_next.col = POS_W_C'(col);
      win_next.row = POS_W_C'(row - ONE_C);
    end else if (drain_load) begin
      fire         = 1'b1;
      win_next.col = POS_W_C'(col);
      win_next.row = POS_W_C'(rows_q - ONE_C);
    end
    border_next = (win_next.col == '0) || (win_next.col == POS_W_C'(cols_q - ONE_C)) ||
                  (win_next.row == '0) || (win_next.row == POS_W_C'(rows_q - ONE_C));
`else
    if (accept && (col >= TWO_C) && (row >= TWO_C)) begin
      fire         = 1'b1;
      win_next.col = POS_W_C'(col - ONE_C);
      win_next.row = POS_W_C'(row - ONE_C);
    end
`endif
  end

  // Column counter also walks the final line during a border-mode drain.
  raster_scan_ctrl_counter #(
    .WIDTH(WIDTH_P)
  ) u_col_cnt (
    .clk  (clk_i),
    .rst  (rst_i),
    .clr  (start_ok),
    .en   (accept | drain_load),
    .wrap (last_col),
    .count(col)
  );

  raster_scan_ctrl_counter #(
    .WIDTH(WIDTH_P)
  ) u_row_cnt (
    .clk  (clk_i),
    .rst  (rst_i),
    .clr  (start_ok),
    .en   (accept & last_col),
    .wrap (1'b0),
    .count(row)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cols_q      <= '0;
      rows_q      <= '0;
      lb_sel_q    <= '0;
      err_q       <= 1'b0;
      win_valid_q <= 1'b0;
      win_q       <= '0;
`ifdef RASTER_SCAN_BORDER_EN
      border_q    <= 1'b0;
      drain_pend  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (size_ok) begin
              state    <= SCAN;
              cols_q   <= cols_i;
              rows_q   <= rows_i;
              lb_sel_q <= '0;
              err_q    <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (accept && last_col) begin
            lb_sel_q <= (lb_sel_q == 2'(LB_LINES_C - 1)) ? 2'd0 : lb_sel_q + 2'd1;
            if (last_row) begin
              state <= DRAIN;
`ifdef RASTER_SCAN_BORDER_EN
              drain_pend <= 1'b1;
`endif
            end
          end
        end
        DRAIN: begin
`ifdef RASTER_SCAN_BORDER_EN
          if (drain_load && last_col) begin
            drain_pend <= 1'b0;
          end
`endif
          if (done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A new window overrides the clear, so a same-cycle handshake reloads without a bubble.
      if (fire) begin
        win_valid_q <= 1'b1;
        win_q       <= win_next;
`ifdef RASTER_SCAN_BORDER_EN
        border_q    <= border_next;
`endif
      end else if (win_ready_i) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  assign win_valid_o = win_valid_q;
  assign win_col_o   = WIDTH_P'(win_q.col);
  assign win_row_o   = WIDTH_P'(win_q.row);
  assign lb_wr_en_o  = accept;
  assign lb_addr_o   = col;
  assign lb_sel_o    = lb_sel_q;
  assign busy_o      = (state != IDLE);
  assign done_o      = done;
  assign err_o       = err_q;
`ifdef RASTER_SCAN_BORDER_EN
  assign border_o    = border_q;
`endif

endmodule
